// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
// Digit arrays are indexed d0 (hundredths) .. d3 (tens of seconds).
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        LAP,
        PAUSED
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Listed d3..d0, so FULL_SCALE[0] is the tens-of-seconds digit.
    localparam bcd_digit_t FULL_SCALE [4] = '{4'd5, 4'd9, 4'd9, 4'd9};

    // Takes the digits packed as {d3, d2, d1, d0}.
    function automatic logic is_full_scale(input logic [15:0] digits);
        return digits == {FULL_SCALE[0], FULL_SCALE[1], FULL_SCALE[2], FULL_SCALE[3]};
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle between the front panel and the controller: raw buttons and live
// digits in, run/clear and display out.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    bcd_digit_t digit [4];
    logic       run;
    logic       clear;
    logic       lap_active;
    logic       sat;
    bcd_digit_t disp [4];

    modport master (
        output btn_ss, btn_lap, btn_clr, digit,
        input  run, clear, lap_active, sat, disp
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, digit,
        output run, clear, lap_active, sat, disp
    );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, and a single
// press pulse on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]      sync_q, sync_d;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // Count consecutive samples that disagree with the accepted level.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounced buttons drive a run/lap/pause
// FSM, a lap latch and the display mux, with optional auto-stop at 59.99.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          AUTO_STOP       = 1'b1
) (
    input logic              clk,
    input logic              reset,
    stopwatch_ctrl_if.slave  sw
);

    logic ss_p, lap_p, clr_p;
    logic ss_e, lap_e, clr_e;
    logic full_hit;

    sw_state_t  state_q, state_d;
    logic       run_q, run_d;
    logic       clear_q, clear_d;
    logic       lap_active_q, lap_active_d;
    logic       sat_q, sat_d;
    bcd_digit_t lap_q [4];
    bcd_digit_t lap_d [4];
    bcd_digit_t live_q [4];
    bcd_digit_t live_d [4];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (sw.btn_ss),
        .press_o (ss_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (sw.btn_lap),
        .press_o (lap_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (sw.btn_clr),
        .press_o (clr_p)
    );

    // clr > ss > lap; a lower-priority pulse is dropped even if the winner is ignored.
    assign clr_e = clr_p;
    assign ss_e  = ss_p & ~clr_p;
    assign lap_e = lap_p & ~clr_p & ~ss_p;

    assign full_hit = AUTO_STOP && ((state_q == RUNNING) || (state_q == LAP)) &&
                      is_full_scale({sw.digit[3], sw.digit[2], sw.digit[1], sw.digit[0]});

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        clear_d      = 1'b0;
        lap_active_d = lap_active_q;
        sat_d        = sat_q;
        lap_d        = lap_q;
        live_d       = sw.digit;
        if (full_hit) begin
            state_d      = PAUSED;
            run_d        = 1'b0;
            sat_d        = 1'b1;
            lap_active_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ss_e) begin
                        state_d = RUNNING;
                        run_d   = 1'b1;
                    end else if (clr_e) begin
                        clear_d = 1'b1;
                        sat_d   = 1'b0;
                    end
                end
                RUNNING: begin
                    if (ss_e) begin
                        state_d = PAUSED;
                        run_d   = 1'b0;
                    end else if (lap_e) begin
                        state_d      = LAP;
                        lap_d        = sw.digit;
                        lap_active_d = 1'b1;
                    end
                end
                LAP: begin
                    if (ss_e) begin
                        state_d      = PAUSED;
                        run_d        = 1'b0;
                        lap_active_d = 1'b0;
                    end else if (lap_e) begin
                        state_d      = RUNNING;
                        lap_active_d = 1'b0;
                    end
                end
                PAUSED: begin
                    if (clr_e) begin
                        state_d = IDLE;
                        clear_d = 1'b1;
                        sat_d   = 1'b0;
                    end else if (ss_e && !sat_q) begin
                        state_d = RUNNING;
                        run_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            clear_q      <= 1'b0;
            lap_active_q <= 1'b0;
            sat_q        <= 1'b0;
            lap_q        <= '{default: '0};
            live_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            clear_q      <= clear_d;
            lap_active_q <= lap_active_d;
            sat_q        <= sat_d;
            lap_q        <= lap_d;
            live_q       <= live_d;
        end
    end

    assign sw.run        = run_q;
    assign sw.clear      = clear_q;
    assign sw.lap_active = lap_active_q;
    assign sw.sat        = sat_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sw.disp[i] = lap_active_q ? lap_q[i] : live_q[i];
        end
    end

endmodule
